// File: rtl/eco32_core_lsu_pkg.sv
// Shared LSU definitions: default page-written-table dimensions and the
// write-back scan state encoding.
package eco32_core_lsu_pkg;

  localparam int unsigned PWT_PAGE_ADDR_WIDTH = 32'd5;
  localparam int unsigned PWT_TID_WIDTH       = 32'd1;
  localparam int unsigned PWT_WID_WIDTH       = 32'd1;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SCAN  = 2'd1,
    SCAN_OFFER = 2'd2,
    SCAN_DONE  = 2'd3
  } pwt_scan_state_e;

endpackage

// File: rtl/eco32_core_lsu_dcu_pwt_if.sv
// Bus bundle of the page-written table: store-hit set/query, refill clear,
// and the write-back scan handshake.
interface eco32_core_lsu_dcu_pwt_if
  import eco32_core_lsu_pkg::*;
#(
  parameter int unsigned PAGE_ADDR_WIDTH = PWT_PAGE_ADDR_WIDTH,
  parameter int unsigned TID_WIDTH       = PWT_TID_WIDTH,
  parameter int unsigned WID_WIDTH       = PWT_WID_WIDTH
) ();

  logic                       i_wen;
  logic [TID_WIDTH-1:0]       i_tid;
  logic [WID_WIDTH-1:0]       i_wid;
  logic [PAGE_ADDR_WIDTH-1:0] i_page;
  logic [WID_WIDTH-1:0]       i_cr_wid;
  logic                       o_pwf;

  logic                       w_clr;
  logic                       w_wen;
  logic [TID_WIDTH-1:0]       w_tid;
  logic [WID_WIDTH-1:0]       w_wid;
  logic [PAGE_ADDR_WIDTH-1:0] w_page;

  logic                       s_req;
  logic [TID_WIDTH-1:0]       s_tid;
  logic [WID_WIDTH-1:0]       s_wid;
  logic                       s_busy;
  logic                       o_scan_vld;
  logic [PAGE_ADDR_WIDTH-1:0] o_scan_page;
  logic                       s_rdy;
  logic                       o_scan_done;

  modport master (
    output i_wen, i_tid, i_wid, i_page, i_cr_wid,
    output w_clr, w_wen, w_tid, w_wid, w_page,
    output s_req, s_tid, s_wid, s_rdy,
    input  o_pwf, s_busy, o_scan_vld, o_scan_page, o_scan_done
  );

  modport slave (
    input  i_wen, i_tid, i_wid, i_page, i_cr_wid,
    input  w_clr, w_wen, w_tid, w_wid, w_page,
    input  s_req, s_tid, s_wid, s_rdy,
    output o_pwf, s_busy, o_scan_vld, o_scan_page, o_scan_done
  );

endinterface

// File: rtl/eco32_core_lsu_dcu_pwt_scan.sv
// Write-back scan of one thread/way: walks pages 0..P-1 once, offers each dirty
// page until accepted and requests its auto-clear. Used when
// ECO32_CORE_LSU_DCU_PWT_SCAN_EN is defined.
module eco32_core_lsu_dcu_pwt_scan
  import eco32_core_lsu_pkg::*;
#(
  parameter int unsigned PAGE_ADDR_WIDTH = PWT_PAGE_ADDR_WIDTH,
  parameter int unsigned TID_WIDTH       = PWT_TID_WIDTH,
  parameter int unsigned WID_WIDTH       = PWT_WID_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_req_i,
  input  logic [TID_WIDTH-1:0]       s_tid_i,
  input  logic [WID_WIDTH-1:0]       s_wid_i,
  input  logic                       s_rdy_i,
  input  logic                       flag_i,
  output logic                       clr_o,
  output logic [TID_WIDTH-1:0]       tid_o,
  output logic [WID_WIDTH-1:0]       wid_o,
  output logic [PAGE_ADDR_WIDTH-1:0] page_o,
  output logic                       busy_o,
  output logic                       vld_o,
  output logic [PAGE_ADDR_WIDTH-1:0] vld_page_o,
  output logic                       done_o
);

  localparam logic [PAGE_ADDR_WIDTH-1:0] LAST_PAGE = '1;

  pwt_scan_state_e            state_q, state_d;
  logic [PAGE_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [TID_WIDTH-1:0]       tid_q, tid_d;
  logic [WID_WIDTH-1:0]       wid_q, wid_d;
  logic                       clr_s;
  logic                       busy_q, vld_q, done_q;
  logic [PAGE_ADDR_WIDTH-1:0] vld_page_q;

  // Next-state, counter advance and auto-clear request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tid_d   = tid_q;
    wid_d   = wid_q;
    clr_s   = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (s_req_i) begin
          tid_d   = s_tid_i;
          wid_d   = s_wid_i;
          cnt_d   = '0;
          state_d = SCAN_SCAN;
        end else begin
          state_d = SCAN_IDLE;
        end
      end
      SCAN_SCAN: begin
        if (flag_i) begin
          state_d = SCAN_OFFER;
        end else if (cnt_q == LAST_PAGE) begin
          state_d = SCAN_DONE;
        end else begin
          cnt_d = cnt_q + PAGE_ADDR_WIDTH'(1);
        end
      end
      SCAN_OFFER: begin
        if (s_rdy_i) begin
          clr_s = 1'b1;
          if (cnt_q == LAST_PAGE) begin
            state_d = SCAN_DONE;
          end else begin
            cnt_d   = cnt_q + PAGE_ADDR_WIDTH'(1);
            state_d = SCAN_SCAN;
          end
        end else begin
          state_d = SCAN_OFFER;
        end
      end
      SCAN_DONE: state_d = SCAN_IDLE;
      default:   state_d = SCAN_IDLE;
    endcase
  end

  // State, latched target and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN_IDLE;
      cnt_q      <= '0;
      tid_q      <= '0;
      wid_q      <= '0;
      busy_q     <= 1'b0;
      vld_q      <= 1'b0;
      vld_page_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tid_q      <= tid_d;
      wid_q      <= wid_d;
      busy_q     <= (state_d != SCAN_IDLE);
      vld_q      <= (state_d == SCAN_OFFER);
      vld_page_q <= (state_d == SCAN_OFFER) ? cnt_d : '0;
      done_q     <= (state_d == SCAN_DONE);
    end
  end

  assign clr_o      = clr_s;
  assign tid_o      = tid_q;
  assign wid_o      = wid_q;
  assign page_o     = cnt_q;
  assign busy_o     = busy_q;
  assign vld_o      = vld_q;
  assign vld_page_o = vld_page_q;
  assign done_o     = done_q;

endmodule

// File: rtl/eco32_core_lsu_dcu_pwt.sv
// Page-written table: one dirty flag per [tid][wid][page] with registered query.
// Write-back scan engine present only when ECO32_CORE_LSU_DCU_PWT_SCAN_EN is defined.
module eco32_core_lsu_dcu_pwt
  import eco32_core_lsu_pkg::*;
#(
  parameter int unsigned PAGE_ADDR_WIDTH = PWT_PAGE_ADDR_WIDTH,
  parameter int unsigned TID_WIDTH       = PWT_TID_WIDTH,
  parameter int unsigned WID_WIDTH       = PWT_WID_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  eco32_core_lsu_dcu_pwt_if.slave bus
);

  localparam int unsigned IDX_W   = TID_WIDTH + WID_WIDTH + PAGE_ADDR_WIDTH;
  localparam int unsigned N_FLAGS = 32'd1 << IDX_W;

  logic [N_FLAGS-1:0] flag_q, flag_d;
  logic               pwf_q;
  logic [IDX_W-1:0]   set_idx_s, clr_idx_s, qry_idx_s, scan_idx_s;
  logic               scan_clr_s;

  assign set_idx_s = {bus.i_tid, bus.i_wid, bus.i_page};
  assign clr_idx_s = {bus.w_tid, bus.w_wid, bus.w_page};
  assign qry_idx_s = {bus.i_tid, bus.i_cr_wid, bus.i_page};

  // Per-entry update: refill clear wins over store set, which wins over scan clear.
  always_comb begin
    flag_d = flag_q;
    for (int k = 0; k < N_FLAGS; k++) begin
      if (bus.w_clr && bus.w_wen && (clr_idx_s == IDX_W'(k))) begin
        flag_d[k] = 1'b0;
      end else if (bus.i_wen && (set_idx_s == IDX_W'(k))) begin
        flag_d[k] = 1'b1;
      end else if (scan_clr_s && (scan_idx_s == IDX_W'(k))) begin
        flag_d[k] = 1'b0;
      end else begin
        flag_d[k] = flag_q[k];
      end
    end
  end

  // Flag storage; the query reads the post-update value so same-cycle writes show through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      pwf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      pwf_q  <= flag_d[qry_idx_s];
    end
  end

  assign bus.o_pwf = pwf_q;

`ifdef ECO32_CORE_LSU_DCU_PWT_SCAN_EN
  logic [TID_WIDTH-1:0]       scan_tid_s;
  logic [WID_WIDTH-1:0]       scan_wid_s;
  logic [PAGE_ADDR_WIDTH-1:0] scan_page_s;

  assign scan_idx_s = {scan_tid_s, scan_wid_s, scan_page_s};

  eco32_core_lsu_dcu_pwt_scan #(
    .PAGE_ADDR_WIDTH (PAGE_ADDR_WIDTH),
    .TID_WIDTH       (TID_WIDTH),
    .WID_WIDTH       (WID_WIDTH)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .s_req_i    (bus.s_req),
    .s_tid_i    (bus.s_tid),
    .s_wid_i    (bus.s_wid),
    .s_rdy_i    (bus.s_rdy),
    .flag_i     (flag_q[scan_idx_s]),
    .clr_o      (scan_clr_s),
    .tid_o      (scan_tid_s),
    .wid_o      (scan_wid_s),
    .page_o     (scan_page_s),
    .busy_o     (bus.s_busy),
    .vld_o      (bus.o_scan_vld),
    .vld_page_o (bus.o_scan_page),
    .done_o     (bus.o_scan_done)
  );
`else
  logic unused_scan_s;

  assign unused_scan_s   = ^{bus.s_req, bus.s_tid, bus.s_wid, bus.s_rdy};
  assign scan_clr_s      = 1'b0;
  assign scan_idx_s      = '0;
  assign bus.s_busy      = 1'b0;
  assign bus.o_scan_vld  = 1'b0;
  assign bus.o_scan_page = '0;
  assign bus.o_scan_done = 1'b0;
`endif

endmodule

// File: tb/tb_eco32_core_lsu_dcu_pwt.sv
// Self-checking bench for eco32_core_lsu_dcu_pwt: per-cycle comparison against a
// behavioural table/scan model, directed scenarios, then randomized traffic.
module tb_eco32_core_lsu_dcu_pwt;

  localparam int PAW = 5;
  localparam int TW  = 1;
  localparam int WW  = 1;
  localparam int P   = 1 << PAW;
  localparam int W   = 1 << WW;
  localparam int T   = 1 << TW;
  localparam int N   = T * W * P;
`ifdef ECO32_CORE_LSU_DCU_PWT_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eco32_core_lsu_dcu_pwt_if #(.PAGE_ADDR_WIDTH(PAW), .TID_WIDTH(TW), .WID_WIDTH(WW)) bus ();

  eco32_core_lsu_dcu_pwt #(.PAGE_ADDR_WIDTH(PAW), .TID_WIDTH(TW), .WID_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: dirty bits, registered query result, scan progress (0 idle, 1 walking, 2 offering, 3 done)
  bit m_flag [N];
  bit m_pwf;
  int m_phase, m_cnt, m_stid, m_swid;

  function automatic int fidx(int t, int w, int p);
    return (t * W + w) * P + p;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_flag[k]) m_flag[k] = 1'b0;
    m_pwf = 1'b0; m_phase = 0; m_cnt = 0; m_stid = 0; m_swid = 0;
  endtask

  task automatic model_edge();
    bit nf [N];
    int sc;
    sc = -1;
    if (rst) begin
      model_reset();
      return;
    end
    if (SCAN_EN) begin
      case (m_phase)
        0: if (bus.s_req) begin
             m_stid = int'(bus.s_tid); m_swid = int'(bus.s_wid); m_cnt = 0; m_phase = 1;
           end
        1: if (m_flag[fidx(m_stid, m_swid, m_cnt)]) m_phase = 2;
           else if (m_cnt == P - 1) m_phase = 3;
           else m_cnt++;
        2: if (bus.s_rdy) begin
             sc = fidx(m_stid, m_swid, m_cnt);
             if (m_cnt == P - 1) m_phase = 3;
             else begin m_cnt++; m_phase = 1; end
           end
        default: m_phase = 0;
      endcase
    end
    nf = m_flag;
    if (sc >= 0) nf[sc] = 1'b0;
    if (bus.i_wen) nf[fidx(int'(bus.i_tid), int'(bus.i_wid), int'(bus.i_page))] = 1'b1;
    if (bus.w_clr && bus.w_wen) nf[fidx(int'(bus.w_tid), int'(bus.w_wid), int'(bus.w_page))] = 1'b0;
    m_flag = nf;
    m_pwf  = m_flag[fidx(int'(bus.i_tid), int'(bus.i_cr_wid), int'(bus.i_page))];
  endtask

  task automatic check_outputs();
    chk("pwf",       int'(bus.o_pwf),       int'(m_pwf));
    chk("s_busy",    int'(bus.s_busy),      (m_phase != 0) ? 1 : 0);
    chk("scan_vld",  int'(bus.o_scan_vld),  (m_phase == 2) ? 1 : 0);
    chk("scan_page", int'(bus.o_scan_page), (m_phase == 2) ? m_cnt : 0);
    chk("scan_done", int'(bus.o_scan_done), (m_phase == 3) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.i_wen = 1'b0; bus.i_tid = '0; bus.i_wid = '0; bus.i_page = '0; bus.i_cr_wid = '0;
    bus.w_clr = 1'b0; bus.w_wen = 1'b0; bus.w_tid = '0; bus.w_wid = '0; bus.w_page = '0;
    bus.s_req = 1'b0; bus.s_tid = '0; bus.s_wid = '0; bus.s_rdy = 1'b0;
  endtask

  task automatic set_page(int t, int w, int p);
    bus.i_wen = 1'b1; bus.i_tid = TW'(t); bus.i_wid = WW'(w); bus.i_page = PAW'(p);
    step();
    bus.i_wen = 1'b0;
  endtask

  task automatic query(int t, int w, int p);
    bus.i_tid = TW'(t); bus.i_cr_wid = WW'(w); bus.i_page = PAW'(p);
    step();
  endtask

  task automatic start_scan(int t, int w, bit rdy);
    bus.s_req = 1'b1; bus.s_tid = TW'(t); bus.s_wid = WW'(w); bus.s_rdy = rdy;
    step();
    bus.s_req = 1'b0;
  endtask

  task automatic wait_vld(string name, int budget);
    for (int n = 0; n < budget && !bus.o_scan_vld; n++) step();
    chk(name, int'(bus.o_scan_vld), 1);
  endtask

  task automatic wait_done(string name, int budget);
    for (int n = 0; n < budget && !bus.o_scan_done; n++) step();
    chk(name, int'(bus.o_scan_done), 1);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int offers [$];
    int dones, lat;
    bit vld_seen;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_pwf", int'(bus.o_pwf), 0);
    chk("rst_busy", int'(bus.s_busy), 0);
    chk("rst_done", int'(bus.o_scan_done), 0);
    rst = 1'b0;
    step();

    // Set then query, plus a different thread at the same page
    set_page(1, 0, 7);
    query(1, 0, 7);
    chk("set_query_hit", int'(bus.o_pwf), 1);
    query(0, 0, 7);
    chk("other_tid_miss", int'(bus.o_pwf), 0);

    // Same-cycle set and clear on one entry: clear wins
    bus.i_wen = 1'b1; bus.i_tid = 1'b0; bus.i_wid = 1'b1; bus.i_page = 5'd3; bus.i_cr_wid = 1'b1;
    bus.w_clr = 1'b1; bus.w_wen = 1'b1; bus.w_tid = 1'b0; bus.w_wid = 1'b1; bus.w_page = 5'd3;
    step();
    idle_inputs();
    query(0, 1, 3);
    chk("clr_beats_set", int'(bus.o_pwf), 0);

    // Clear request without w_wen leaves the flag alone
    set_page(0, 1, 3);
    bus.w_clr = 1'b1; bus.w_wen = 1'b0; bus.w_tid = 1'b0; bus.w_wid = 1'b1; bus.w_page = 5'd3;
    step();
    idle_inputs();
    query(0, 1, 3);
    chk("clr_needs_wen", int'(bus.o_pwf), 1);
    bus.w_clr = 1'b1; bus.w_wen = 1'b1; bus.w_tid = 1'b0; bus.w_wid = 1'b1; bus.w_page = 5'd3;
    step();
    idle_inputs();

`ifdef ECO32_CORE_LSU_DCU_PWT_SCAN_EN
    // Dirty pages 0, 5, 31 offered in order with s_rdy held high
    set_page(0, 1, 0);
    set_page(0, 1, 5);
    set_page(0, 1, 31);
    start_scan(0, 1, 1'b1);
    dones = 0;
    for (int n = 0; n < 45; n++) begin
      step();
      if (bus.o_scan_vld) offers.push_back(int'(bus.o_scan_page));
      if (bus.o_scan_done) dones++;
    end
    chk("offer_count", offers.size(), 3);
    if (offers.size() == 3) begin
      chk("offer0", offers[0], 0);
      chk("offer1", offers[1], 5);
      chk("offer2", offers[2], 31);
    end
    chk("done_pulses", dones, 1);
    bus.s_rdy = 1'b0;
    query(0, 1, 0);  chk("cleared_p0",  int'(bus.o_pwf), 0);
    query(0, 1, 5);  chk("cleared_p5",  int'(bus.o_pwf), 0);
    query(0, 1, 31); chk("cleared_p31", int'(bus.o_pwf), 0);

    // Empty way: done exactly P+1 cycles after the request, never an offer
    start_scan(1, 1, 1'b1);
    lat = 1;
    vld_seen = 1'b0;
    while (!bus.o_scan_done && lat < 40) begin
      step();
      lat++;
      if (bus.o_scan_vld) vld_seen = 1'b1;
    end
    chk("empty_scan_latency", lat, 33);
    chk("empty_scan_no_vld", int'(vld_seen), 0);
    step();

    // Stalled offer stays stable; a store set on the accept cycle keeps the flag
    set_page(0, 0, 9);
    start_scan(0, 0, 1'b0);
    wait_vld("stall_offer_reached", 40);
    for (int n = 0; n < 10; n++) begin
      step();
      chk("stall_vld", int'(bus.o_scan_vld), 1);
      chk("stall_page", int'(bus.o_scan_page), 9);
    end
    bus.s_rdy = 1'b1;
    bus.i_wen = 1'b1; bus.i_tid = 1'b0; bus.i_wid = 1'b0; bus.i_page = 5'd9; bus.i_cr_wid = 1'b0;
    step();
    bus.i_wen = 1'b0;
    step();
    chk("set_beats_autoclr", int'(bus.o_pwf), 1);
    wait_done("stall_scan_done", 40);

    // Reset in the middle of an offer
    set_page(1, 1, 4);
    start_scan(1, 1, 1'b0);
    wait_vld("rst_offer_reached", 40);
    rst = 1'b1;
    #1;
    chk("midrst_pwf", int'(bus.o_pwf), 0);
    chk("midrst_busy", int'(bus.s_busy), 0);
    chk("midrst_vld", int'(bus.o_scan_vld), 0);
    chk("midrst_page", int'(bus.o_scan_page), 0);
    chk("midrst_done", int'(bus.o_scan_done), 0);
    model_reset();
    step();
    rst = 1'b0;
    query(1, 1, 4);
    chk("midrst_flag_cleared", int'(bus.o_pwf), 0);
    query(1, 0, 7);
    chk("midrst_old_flag_cleared", int'(bus.o_pwf), 0);
    start_scan(1, 1, 1'b1);
    chk("restart_busy", int'(bus.s_busy), 1);
    wait_done("restart_done", 40);
`else
    start_scan(0, 0, 1'b1);
    chk("noscan_busy", int'(bus.s_busy), 0);
`endif

    // Randomized traffic with small address space to force collisions
    for (int n = 0; n < 3000; n++) begin
      bus.i_wen    = ($urandom_range(0, 3) == 0);
      bus.i_tid    = TW'($urandom_range(0, T - 1));
      bus.i_wid    = WW'($urandom_range(0, W - 1));
      bus.i_cr_wid = WW'($urandom_range(0, W - 1));
      bus.i_page   = PAW'($urandom_range(0, P - 1));
      bus.w_clr    = ($urandom_range(0, 3) == 0);
      bus.w_wen    = ($urandom_range(0, 1) == 0);
      bus.w_tid    = TW'($urandom_range(0, T - 1));
      bus.w_wid    = WW'($urandom_range(0, W - 1));
      bus.w_page   = ($urandom_range(0, 1) == 0) ? bus.i_page : PAW'($urandom_range(0, P - 1));
      bus.s_req    = ($urandom_range(0, 19) == 0);
      bus.s_tid    = TW'($urandom_range(0, T - 1));
      bus.s_wid    = WW'($urandom_range(0, W - 1));
      bus.s_rdy    = ($urandom_range(0, 1) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eco32_core_lsu_dcu_pwt.md
ECO32_CORE_LSU_DCU_PWT -- requirements
Module: eco32_core_lsu_dcu_pwt

Interface
REQ-001 Parameter PAGE_ADDR_WIDTH, default 5, page index width; pages per way P = 2^PAGE_ADDR_WIDTH.
REQ-002 Parameter TID_WIDTH, default 1, thread index width; threads T = 2^TID_WIDTH.
REQ-003 Parameter WID_WIDTH, default 1, way index width; ways W = 2^WID_WIDTH.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_wen, i_tid, i_wid, i_page  in  1/TID_WIDTH/WID_WIDTH/PAGE_ADDR_WIDTH  store-hit set request and query address.
REQ-007 i_cr_wid  in  WID_WIDTH  way selected for the query.
REQ-008 o_pwf  out  1  page-written flag of queried entry.
REQ-009 w_clr, w_wen, w_tid, w_wid, w_page  in  1/1/TID_WIDTH/WID_WIDTH/PAGE_ADDR_WIDTH  refill clear request; clears only when w_clr & w_wen.
REQ-010 s_req, s_tid, s_wid  in  1/TID_WIDTH/WID_WIDTH  start write-back scan of one thread/way.
REQ-011 s_busy  out  1  scan active.
REQ-012 o_scan_vld, o_scan_page  out  1/PAGE_ADDR_WIDTH  dirty page offered to write-back.
REQ-013 s_rdy  in  1  write-back accepts offered page.
REQ-014 o_scan_done  out  1  one-cycle pulse at scan end.

Function
REQ-015 Storage SHALL be T*W*P flag bits in flops, indexed [tid][wid][page].
REQ-016 Set: i_wen SHALL set flag[i_tid][i_wid][i_page] at the clock edge of the request (written flag visible next cycle).
REQ-017 Clear: w_clr & w_wen SHALL clear flag[w_tid][w_wid][w_page] at the same edge.
REQ-018 Same entry, same cycle: w clear beats i set; i set beats scan auto-clear; different entries update independently.
REQ-019 o_pwf SHALL be registered, 1-cycle latency: value in cycle n+1 = flag[i_tid][i_cr_wid][i_page] after cycle-n updates (write-through bypass).
REQ-020 Scan FSM states IDLE, SCAN, OFFER, DONE.
REQ-021 IDLE: s_req latches s_tid/s_wid, page counter <= 0, -> SCAN; s_req ignored outside IDLE.
REQ-022 SCAN: flag[counter] set -> OFFER; clear -> counter+1, or DONE if counter == P-1.
REQ-023 OFFER: o_scan_vld=1, o_scan_page=counter, held stable until s_rdy; on s_rdy & o_scan_vld flag auto-cleared, then counter+1 -> SCAN, or DONE if counter == P-1.
REQ-024 OFFER entry cleared by w port before s_rdy: offer still completes (page written back once, harmless).
REQ-025 Pages set behind the counter during a scan SHALL remain set and unreported.
REQ-026 DONE: o_scan_done=1 for exactly one cycle, -> IDLE; counter never wraps past P-1.
REQ-027 s_busy=1 in SCAN, OFFER, DONE.
REQ-028 Worst-case scan with no dirty pages: P+1 cycles from s_req to o_scan_done.

Reset
REQ-029 rst SHALL clear all flags, o_pwf=0, FSM=IDLE, counter=0, s_busy=0, o_scan_vld=0, o_scan_page=0, o_scan_done=0, including mid-scan (no done pulse).

Configuration
REQ-030 Macro ECO32_CORE_LSU_DCU_PWT_SCAN_EN: defined -> scan FSM present per REQ-020..028; undefined -> no FSM, s_busy/o_scan_vld/o_scan_page/o_scan_done tied 0, s_req/s_tid/s_wid/s_rdy ignored, set/clear/query unchanged.

Structure
REQ-031 Scan state encoding and default parameter constants SHALL live in shared package eco32_core_lsu_pkg.
REQ-032 Scan FSM and counter SHALL be sub-module eco32_core_lsu_dcu_pwt_scan, instantiated under ECO32_CORE_LSU_DCU_PWT_SCAN_EN.

Verification
REQ-033 Set tid1/wid0/page 7, next cycle query same entry -> o_pwf=1 one cycle later; query tid0/wid0/page 7 -> 0.
REQ-034 Same cycle i set and w clear on tid0/wid1/page 3 -> subsequent query returns 0.
REQ-035 Set pages 0, 5, 31 on tid0/wid1, scan with s_rdy=1 -> offers 0, 5, 31 in order, o_scan_done once, all three flags then 0.
REQ-036 Scan empty way -> o_scan_done exactly 33 cycles after s_req (P=32), no o_scan_vld.
REQ-037 Hold s_rdy=0 in OFFER for 10 cycles -> o_scan_vld and o_scan_page stable; i set on offered page at s_rdy cycle -> flag stays 1.
REQ-038 Assert rst during OFFER -> all outputs 0, all flags 0, no o_scan_done; scan restartable next cycle.
